// File: rtl/instr_encoder.sv
// Instruction encoder: validates operand bundles, assembles R/I/J words through one
// pipeline register into a 4-entry FIFO and tags each word with its memory address.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_onehot,
    input  logic [1:0]  fmt,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [1:0] FmtR = 2'b00;
    localparam logic [1:0] FmtI = 2'b01;
    localparam logic [1:0] FmtJ = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] addr_ptr_q;
    logic        err_q;
    logic [7:0]  err_count_q;

    logic        pipe_valid_q;
    logic [31:0] pipe_word_q;
    logic [31:0] pipe_addr_q;

    logic [63:0] fifo_mem [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;

    logic [4:0]  op_idx;
    logic        op_is_onehot;
    logic [5:0]  op_code;
    logic        legal;
    logic [31:0] enc_word;

    logic        fifo_empty, fifo_full, pop, can_push, pipe_move, accept;

    always_comb begin
        op_idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (op_onehot[i]) op_idx = 5'(i);
        end
    end

    assign op_is_onehot = (op_onehot != '0) && ((op_onehot & (op_onehot - 32'd1)) == '0);

    always_comb begin
        case (op_idx)
            5'd0:    op_code = 6'b100110;
            5'd1:    op_code = 6'b000000;
            5'd2:    op_code = 6'b000100;
            5'd3:    op_code = 6'b000010;
            5'd4:    op_code = 6'b100010;
            5'd5:    op_code = 6'b000110;
            5'd6:    op_code = 6'b101010;
            5'd7:    op_code = 6'b001100;
            5'd8:    op_code = 6'b100011;
            5'd9:    op_code = 6'b100101;
            5'd10:   op_code = 6'b100111;
            5'd11:   op_code = 6'b100001;
            5'd12:   op_code = 6'b011000;
            5'd13:   op_code = 6'b011010;
            5'd14:   op_code = 6'b100100;
            5'd15:   op_code = 6'b100000;
            5'd16:   op_code = 6'b001000;
            5'd17:   op_code = 6'b000011;
            5'd18:   op_code = 6'b001001;
            5'd19:   op_code = 6'b001110;
            5'd20:   op_code = 6'b001101;
            5'd21:   op_code = 6'b000101;
            5'd22:   op_code = 6'b000110;
            5'd23:   op_code = 6'b000111;
            5'd24:   op_code = 6'b000001;
            5'd25:   op_code = 6'b101011;
            5'd26:   op_code = 6'b101000;
            5'd27:   op_code = 6'b001010;
            5'd28:   op_code = 6'b001111;
            default: op_code = 6'b000000;
        endcase
    end

    always_comb begin
        legal = op_is_onehot && (op_idx <= 5'd28);
        case (fmt)
            FmtR:    if (op_idx >= 5'd18) legal = 1'b0;
            FmtI:    ;
            FmtJ:    if (op_idx != 5'd3 && op_idx != 5'd17) legal = 1'b0;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (fmt)
            FmtR:    enc_word = {6'b000000, rs, rt, rd, shamt, op_code};
            FmtI:    enc_word = {op_code, rs, rt, imm};
            default: enc_word = {op_code, target};
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still take the pipeline word.
    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign pop        = !fifo_empty && out_ready;
    assign can_push   = !fifo_full || pop;
    assign pipe_move  = pipe_valid_q && can_push;
    assign in_ready   = (state_q == StRun) && (!pipe_valid_q || can_push);
    assign accept     = in_valid && in_ready;

    assign out_valid = !fifo_empty;
    assign out_word  = out_valid ? fifo_mem[rd_ptr_q][63:32] : '0;
    assign out_addr  = out_valid ? fifo_mem[rd_ptr_q][31:0] : '0;
    assign err       = err_q;
    assign err_count = err_count_q;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        busy    = (state_q != StIdle);
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (finish) state_d = StDrain;
            StDrain: if (fifo_empty && !pipe_valid_q) state_d = StDone;
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_ptr_q   <= '0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            pipe_valid_q <= 1'b0;
            pipe_word_q  <= '0;
            pipe_addr_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && !legal;
            if (accept && !legal && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;

            if (state_q == StIdle && start) begin
                addr_ptr_q <= base_addr;
            end else if (accept && legal) begin
                addr_ptr_q <= addr_ptr_q + 32'd4;
            end

            if (accept && legal) begin
                pipe_valid_q <= 1'b1;
                pipe_word_q  <= enc_word;
                pipe_addr_q  <= addr_ptr_q;
            end else if (pipe_move) begin
                pipe_valid_q <= 1'b0;
            end

            if (pipe_move) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + 3'(pipe_move) - 3'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (pipe_move) fifo_mem[wr_ptr_q] <= {pipe_word_q, pipe_addr_q};
    end

endmodule
